// File: rtl/pwm_multi_ch_if.sv
// Control/status bundle of the multi-channel PWM: CPU-side register inputs and pin-side outputs.
interface pwm_multi_ch_if #(
    parameter int CH       = 4,
    parameter int RES_BITS = 10,
    parameter int DIV_BITS = 16
);
    logic                     enable;
    logic [RES_BITS-1:0]      period;
    logic [DIV_BITS-1:0]      prescale;
    logic                     center_mode;
    logic [CH*RES_BITS-1:0]   duty;
    logic [CH-1:0]            polarity;
    logic                     update_req;
    logic [CH-1:0]            pwm_out;
    logic                     period_start;
    logic                     update_ack;
    logic [RES_BITS-1:0]      cnt_out;

    modport master (
        output enable, period, prescale, center_mode, duty, polarity, update_req,
        input  pwm_out, period_start, update_ack, cnt_out
    );

    modport slave (
        input  enable, period, prescale, center_mode, duty, polarity, update_req,
        output pwm_out, period_start, update_ack, cnt_out
    );
endinterface

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: shared prescaler and edge/center-aligned period counter,
// double-buffered configuration applied at period boundaries, per-channel compare.
module pwm_ch #(
    parameter int RES_BITS = 10
) (
    input  logic                clk,
    input  logic                reset_p,
    input  logic                enable,
    input  logic [RES_BITS-1:0] cnt,
    input  logic [RES_BITS-1:0] duty,
    input  logic                polarity,
    output logic                pwm_out
);
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) pwm_out <= 1'b0;
        else         pwm_out <= (enable && (cnt < duty)) ^ polarity;
    end
endmodule

module pwm_multi_ch #(
    parameter int CH       = 4,
    parameter int RES_BITS = 10,
    parameter int DIV_BITS = 16
) (
    input  logic           clk,
    input  logic           reset_p,
    pwm_multi_ch_if.slave  bus
);
    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

    logic [RES_BITS-1:0]          sh_period,   act_period;
    logic [DIV_BITS-1:0]          sh_prescale, act_prescale;
    logic                         sh_center,   act_center;
    logic [CH-1:0][RES_BITS-1:0]  sh_duty,     act_duty;
    logic                         pending;

    logic [DIV_BITS-1:0]          psc, psc_nxt;
    logic [RES_BITS-1:0]          cnt, cnt_nxt;
    dir_t                         dir, dir_nxt;
    logic                         en_q;
    logic                         tick, edge_eff, boundary, apply;
    logic                         period_start_q, update_ack_q;
    logic [CH-1:0]                pwm_q;

    // Center mode with TOP==0 cannot turn around, so it runs as edge mode.
    assign tick     = bus.enable && (psc == act_prescale);
    assign edge_eff = !act_center || (act_period == '0);
    assign apply    = pending && (boundary || !bus.enable);

    always_comb begin
        cnt_nxt  = cnt;
        dir_nxt  = dir;
        boundary = 1'b0;
        psc_nxt  = (!bus.enable || tick) ? '0 : psc + 1'b1;
        if (!bus.enable) begin
            cnt_nxt = '0;
            dir_nxt = UP;
        end else if (tick) begin
            if (edge_eff) begin
                dir_nxt = UP;
                if (cnt >= act_period) begin
                    cnt_nxt  = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else if (dir == UP) begin
                if (cnt >= act_period) begin
                    // TOP==1 would turn around straight onto 0: that is the boundary itself.
                    if (act_period == RES_BITS'(1)) begin
                        cnt_nxt  = '0;
                        boundary = 1'b1;
                    end else begin
                        cnt_nxt = act_period - 1'b1;
                        dir_nxt = DOWN;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else begin
                if (cnt <= RES_BITS'(1)) begin
                    cnt_nxt  = '0;
                    dir_nxt  = UP;
                    boundary = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
        end
        if (apply && (sh_center != act_center)) begin
            cnt_nxt = '0;
            dir_nxt = UP;
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            psc            <= '0;
            cnt            <= '0;
            dir            <= UP;
            en_q           <= 1'b0;
            period_start_q <= 1'b0;
            update_ack_q   <= 1'b0;
        end else begin
            psc            <= psc_nxt;
            cnt            <= cnt_nxt;
            dir            <= dir_nxt;
            en_q           <= bus.enable;
            period_start_q <= boundary || (bus.enable && !en_q);
            update_ack_q   <= apply;
        end
    end

    // A capture in the apply cycle lands in the shadow after the old shadow moves out.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            sh_period    <= '0;
            sh_prescale  <= '0;
            sh_center    <= 1'b0;
            sh_duty      <= '0;
            act_period   <= '0;
            act_prescale <= '0;
            act_center   <= 1'b0;
            act_duty     <= '0;
            pending      <= 1'b0;
        end else begin
            if (apply) begin
                act_period   <= sh_period;
                act_prescale <= sh_prescale;
                act_center   <= sh_center;
                act_duty     <= sh_duty;
            end
            if (bus.update_req) begin
                sh_period   <= bus.period;
                sh_prescale <= bus.prescale;
                sh_center   <= bus.center_mode;
                sh_duty     <= bus.duty;
                pending     <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        pwm_ch #(.RES_BITS(RES_BITS)) u_ch (
            .clk      (clk),
            .reset_p  (reset_p),
            .enable   (bus.enable),
            .cnt      (cnt),
            .duty     (act_duty[k]),
            .polarity (bus.polarity[k]),
            .pwm_out  (pwm_q[k])
        );
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.period_start = period_start_q;
    assign bus.update_ack   = update_ack_q;
    assign bus.cnt_out      = cnt;
endmodule

// File: doc/pwm_multi_ch.md
Name: pwm_multi_ch

Overview:
Multi-channel PWM generator. It is the parametrised successor of the single-channel 1000-step PWM block. All channels share one prescaler and one period counter. Each channel has its own duty and output polarity. Edge-aligned and center-aligned modes are supported. Period, prescale, mode and duties are double-buffered and take effect only at a period boundary, so output pulses are never torn. It sits between CPU-side control registers and motor/LED/servo pins.

Parameters:
CH, 4, number of PWM channels
RES_BITS, 10, width of counter, period and duty values
DIV_BITS, 16, width of prescaler

Ports:
clk  in  1  system clock
reset_p  in  1  asynchronous active-high reset
enable  in  1  1 = run; 0 = counters held at 0, outputs at inactive level
period  in  RES_BITS  counter top value (TOP)
prescale  in  DIV_BITS  tick every prescale+1 clocks
center_mode  in  1  0 = edge-aligned, 1 = center-aligned
duty  in  CH*RES_BITS  flattened duties; channel k = duty[k*RES_BITS +: RES_BITS]
polarity  in  CH  1 = invert channel output
update_req  in  1  one-clock pulse: capture period/prescale/center_mode/duty into shadow
pwm_out  out  CH  PWM outputs, registered
period_start  out  1  one-clock pulse when the counter restarts a period
update_ack  out  1  one-clock pulse when shadow values become active
cnt_out  out  RES_BITS  current counter value, for debug

Behaviour:
- Reset values: active regs, shadow regs, prescaler, counter, direction (up), pending flag all 0. pwm_out=0, period_start=0, update_ack=0.
- polarity is not buffered. It applies combinationally before the output register.
- Shadow capture:
  - update_req=1 latches all four inputs into shadow on that clk edge and sets pending.
  - A second update_req before apply overwrites the shadow; pending stays set.
- Apply:
  - On a boundary tick with pending=1: active <= shadow, pending <= 0, update_ack=1 for one clock.
  - update_req in the same cycle as a boundary: the old shadow is applied and the new capture stays pending until the next boundary.
- enable=0:
  - Prescaler and counter are forced to 0 and direction to up.
  - pending=1 applies on the next clock with an update_ack pulse.
  - pwm_out = polarity.
- Prescaler: counts 0..active prescale. tick=1 in the cycle it equals prescale, and it then wraps to 0. prescale=0 means a tick every clock.
- Edge mode:
  - On tick, the counter goes 0..TOP and then wraps to 0.
  - Boundary = tick with cnt==TOP. Period = (TOP+1)*(prescale+1) clocks.
- Center mode (TOP>=1):
  - On tick, the counter counts up to TOP, then down.
  - Up with cnt==TOP: dir <= down, cnt <= TOP-1.
  - Down with cnt==1: cnt <= 0, dir <= up, boundary.
  - Period = 2*TOP ticks.
  - Center mode with TOP==0 behaves as edge mode.
- Mode change at apply: cnt <= 0, dir <= up.
- period_start: registered. It is high in the clock where cnt becomes 0 at a boundary, and also in the first clock after enable rises.
- Compare, per channel, every clock:
  - raw_k = enable && (cnt < duty_k).
  - pwm_out_k <= raw_k ^ polarity_k.
  - Output lags cnt by one clock.
  - Comparison is unsigned, full RES_BITS width.
- Duty limits:
  - duty=0 gives constant inactive level.
  - duty > TOP (edge mode) or duty >= TOP+1 gives 100% (active for the whole period).
  - In center mode, high time = 2*duty-1 ticks for 1<=duty<=TOP, and 100% for duty>TOP.
- Asynchronous reset mid-period: everything returns immediately to reset values and the pending update is discarded.

Test Plan:
1. CH=4, RES_BITS=10, prescale=0, edge mode, period=999, duty0=250, update_req, enable → after the first boundary, pwm_out[0] is high for 250 clocks of every 1000 and period_start pulses every 1000 clocks.
2. Duty limits, period=99: duty0=0, duty1=100, duty2=1023, duty3=50, polarity=4'b1000 → ch0 constant 0; ch1 and ch2 constant 1; ch3 low for 50 clocks and high for 50 clocks.
3. Shadow timing: while running with duty0=250, pulse update_req with duty0=500 at cnt=600 → the current period keeps 250 high; update_ack pulses together with the next period_start; the next period has 500 high.
4. Center mode: period=100, prescale=1, duty0=40 → period = 400 clocks; high 158 clocks (79 ticks) centred on cnt=0; period_start every 400 clocks.
5. Simultaneous update_req at the boundary cycle, then enable=0 with a pending update → update_ack on the next clock, cnt_out=0, pwm_out=polarity.
6. reset_p asserted mid-period with pending=1 → pwm_out=0 and cnt_out=0 immediately. After release and enable, the old active values (all 0) are in effect and no update_ack pulse occurs.
